// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_ctrl
// Purpose  : CPU load/store port to on-chip byte RAM / 4-bit peripheral bus,
//            with a bounded wait for peripheral read responses.
// Revision : 1.0 - initial release
// ============================================================================

module mem_bus_ctrl #(
    parameter int RAM_ADDR_W     = 5,
    parameter int PERIPH_TIMEOUT = 4
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic [15:0] cpu_addr_in,
    input  logic [7:0]  cpu_wdata_in,
    input  logic        cpu_we_in,
    input  logic        cpu_req_in,
    output logic [7:0]  cpu_rdata_out,
    output logic        cpu_ack_out,
    output logic        cpu_err_out,
    output logic [3:0]  periph_addr_out,
    output logic        periph_addr_valid_out,
    output logic        periph_write_en_out,
    output logic [7:0]  periph_data_out,
    input  logic [7:0]  periph_data_in,
    input  logic        periph_data_valid_in
);

    localparam int          RAM_DEPTH   = 1 << RAM_ADDR_W;
    localparam logic [3:0]  TIMEOUT_CNT = 4'(PERIPH_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RAM_RD = 3'd1,
        P_REQ  = 3'd2,
        P_WAIT = 3'd3,
        ACK    = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [3:0]              cnt_nxt;
    logic [3:0]              cnt_inc;
    logic [RAM_ADDR_W-1:0]   idx_q;
    logic                    we_q;
    logic                    latch_req;
    logic                    is_periph;
    logic                    ram_we;

    logic [7:0]              rdata_nxt;
    logic                    ack_nxt;
    logic                    err_nxt;
    logic                    pav_nxt;
    logic                    pwe_nxt;
    logic [3:0]              paddr_nxt;
    logic [7:0]              pdata_nxt;

    logic [7:0]              ram [RAM_DEPTH];

    // Address bits between the RAM index and the decode nibble are don't-care.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr_in;

    assign is_periph = (cpu_addr_in[15:12] == 4'hF);
    assign cnt_inc   = cnt + 4'd1;

    // RAM writes commit on the accepting edge so a write acks one cycle later.
    assign ram_we = reset_n_in && (state == IDLE) && cpu_req_in &&
                    !is_periph && cpu_we_in;

    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[cpu_addr_in[RAM_ADDR_W-1:0]] <= cpu_wdata_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state                 <= IDLE;
            cnt                   <= 4'd0;
            idx_q                 <= '0;
            we_q                  <= 1'b0;
            cpu_rdata_out         <= 8'h00;
            cpu_ack_out           <= 1'b0;
            cpu_err_out           <= 1'b0;
            periph_addr_out       <= 4'h0;
            periph_addr_valid_out <= 1'b0;
            periph_write_en_out   <= 1'b0;
            periph_data_out       <= 8'h00;
        end else begin
            state                 <= state_nxt;
            cnt                   <= cnt_nxt;
            cpu_rdata_out         <= rdata_nxt;
            cpu_ack_out           <= ack_nxt;
            cpu_err_out           <= err_nxt;
            periph_addr_out       <= paddr_nxt;
            periph_addr_valid_out <= pav_nxt;
            periph_write_en_out   <= pwe_nxt;
            periph_data_out       <= pdata_nxt;
            if (latch_req) begin
                idx_q <= cpu_addr_in[RAM_ADDR_W-1:0];
                we_q  <= cpu_we_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_req = 1'b0;
        rdata_nxt = cpu_rdata_out;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        pav_nxt   = 1'b0;
        pwe_nxt   = periph_write_en_out;
        paddr_nxt = periph_addr_out;
        pdata_nxt = periph_data_out;

        case (state)
            IDLE: begin
                if (cpu_req_in) begin
                    latch_req = 1'b1;
                    if (is_periph) begin
                        state_nxt = P_REQ;
                        pav_nxt   = 1'b1;
                        pwe_nxt   = cpu_we_in;
                        paddr_nxt = cpu_addr_in[3:0];
                        pdata_nxt = cpu_wdata_in;
                    end else if (cpu_we_in) begin
                        state_nxt = ACK;
                        ack_nxt   = 1'b1;
                    end else begin
                        state_nxt = RAM_RD;
                    end
                end
            end

            RAM_RD: begin
                rdata_nxt = ram[idx_q];
                state_nxt = ACK;
                ack_nxt   = 1'b1;
            end

            P_REQ: begin
                if (we_q) begin
                    state_nxt = ACK;
                    ack_nxt   = 1'b1;
                end else begin
                    cnt_nxt   = 4'd0;
                    state_nxt = P_WAIT;
                end
            end

            P_WAIT: begin
                if (periph_data_valid_in) begin
                    rdata_nxt = periph_data_in;
                    state_nxt = ACK;
                    ack_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                    // Give up after the last permitted wait cycle; read data is forced to zero.
                    if (cnt_inc == TIMEOUT_CNT) begin
                        rdata_nxt = 8'h00;
                        err_nxt   = 1'b1;
                        ack_nxt   = 1'b1;
                        state_nxt = ACK;
                    end
                end
            end

            ACK: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory bus controller between the CPU core's load/store port and the memory/peripheral bus.
- Decodes each CPU access to either a small on-chip byte RAM or the peripheral block's 4-bit register bus (addresses 0xFxxx).
- Converts a CPU req/ack handshake into single-cycle peripheral strobes.
- Collects peripheral read responses, with a timeout so the CPU cannot hang.

Parameters:
- RAM_ADDR_W, 5, RAM index width; RAM depth = 2^RAM_ADDR_W bytes.
- PERIPH_TIMEOUT, 4, maximum number of P_WAIT cycles spent waiting for periph_data_valid_in on a read (legal range 1..15).

Ports:
- clk_in  input  1  clock.
- reset_n_in  input  1  synchronous reset, active-low.
- cpu_addr_in  input  16  access address.
- cpu_wdata_in  input  8  write data.
- cpu_we_in  input  1  1 = write, 0 = read.
- cpu_req_in  input  1  access request, sampled only in IDLE.
- cpu_rdata_out  output  8  read data, valid while cpu_ack_out=1 for reads.
- cpu_ack_out  output  1  single-cycle completion pulse.
- cpu_err_out  output  1  peripheral read timeout flag, qualified by cpu_ack_out.
- periph_addr_out  output  4  peripheral register address.
- periph_addr_valid_out  output  1  one-cycle access strobe.
- periph_write_en_out  output  1  1 = write.
- periph_data_out  output  8  write data to the peripheral.
- periph_data_in  input  8  read data from the peripheral.
- periph_data_valid_in  input  1  peripheral read response valid.

Behaviour:
- One clock; reset is synchronous and active-low. When reset_n_in=0 at an edge, all state is cleared.
- Reset values: state=IDLE; cpu_ack_out=0; cpu_err_out=0; cpu_rdata_out=0x00; periph_addr_valid_out=0; periph_write_en_out=0; periph_addr_out=0x0; periph_data_out=0x00; timeout counter=0. RAM contents are not cleared.
- Reset mid-transaction returns to IDLE with no ack. Any in-flight peripheral response is ignored.
- Decode:
  - cpu_addr_in[15:12]==4'hF: peripheral; register = cpu_addr_in[3:0].
  - Otherwise: RAM; index = cpu_addr_in[RAM_ADDR_W-1:0]. Upper bits are ignored, so the RAM aliases across 0x0000-0xEFFF.
- Address, wdata and we are latched when the request is accepted. Later changes on cpu_* inputs do not affect the transaction in flight.
- All outputs are registered.
- FSM states: IDLE, RAM_RD, P_REQ, P_WAIT, ACK.
  - IDLE, cpu_req_in=1:
    - RAM write: write the byte at this edge, go to ACK.
    - RAM read: go to RAM_RD.
    - Peripheral access: go to P_REQ, driving periph_addr_out, periph_write_en_out and periph_data_out, with periph_addr_valid_out=1.
  - RAM_RD: register RAM[index] into cpu_rdata_out, go to ACK.
  - P_REQ: periph_addr_valid_out is high for exactly this one cycle.
    - Write: go to ACK.
    - Read: clear the counter, go to P_WAIT.
  - P_WAIT:
    - If periph_data_valid_in=1: latch periph_data_in into cpu_rdata_out, go to ACK.
    - Else increment the counter. When the counter reaches PERIPH_TIMEOUT, load cpu_rdata_out=0x00, set the error flag, go to ACK.
  - ACK: cpu_ack_out=1 (and cpu_err_out=1 on timeout) for exactly one cycle, then IDLE.
- Latency, with req first seen in IDLE in cycle C (ack-high cycle):
  - RAM write: C+1.
  - RAM read: C+2.
  - Peripheral write: C+2.
  - Peripheral read with an immediate response: C+3.
  - Timeout: C+2+PERIPH_TIMEOUT.
- Handshake:
  - The CPU drops cpu_req_in in the ack cycle unless issuing another access.
  - cpu_req_in high in the cycle after ACK is a new request (back-to-back allowed, one idle cycle between transactions).
- cpu_rdata_out holds its last value. It changes only on read completion; writes leave it unchanged.
- cpu_err_out is only ever set on a peripheral read timeout. Writes never error.
- periph_data_valid_in outside P_WAIT is ignored.
- A late response after a timeout is ignored.
- periph_addr_valid_out never stays high for two consecutive cycles, so peripheral side effects (e.g. an SPI data write) happen exactly once.

Test Plan:
- Reset with reset_n_in=0 for 2 cycles while cpu_req_in=1 -> all outputs at reset values, no ack. Then write 0x5A to 0x0003 -> ack at C+1. Read 0x0003 -> ack at C+2 with cpu_rdata_out=0x5A, err=0.
- With RAM_ADDR_W=5: write 0xC3 to 0x0023, read 0x0003 -> 0xC3 (aliasing). Read 0xF0xx is not RAM: routed to the peripheral, periph_addr_out=cpu_addr_in[3:0].
- Peripheral write 0xA5 to 0xF001 -> one-cycle strobe with periph_addr_out=1, periph_write_en_out=1, periph_data_out=0xA5; ack at C+2, err=0.
- Peripheral read 0xF002, model returns 0x3C with valid one cycle after the strobe -> ack at C+3, cpu_rdata_out=0x3C, err=0.
- Peripheral read with no response, PERIPH_TIMEOUT=4 -> ack and err at C+6 with cpu_rdata_out=0x00. A valid arriving at C+7 is ignored, and the next RAM read returns correct data.
- cpu_req_in held high for 3 RAM writes -> exactly 3 ack pulses, each separated by one IDLE cycle. Reset asserted during P_WAIT -> IDLE, no ack, subsequent peripheral read completes normally.
